// File: rtl/aes_pkg.sv
// ============================================================================
// Module : aes_pkg
// Brief  : Shared loader constants and state encoding for the AES input path.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

   localparam int WORDS_PER_BLOCK     = 4;
   localparam int TIMEOUT_CYC_DEFAULT = 64;

   typedef logic [2:0] aes_state_t;

   localparam aes_state_t ST_IDLE  = 3'd0;
   localparam aes_state_t ST_KEY   = 3'd1;
   localparam aes_state_t ST_DATA  = 3'd2;
   localparam aes_state_t ST_RUN   = 3'd3;
   localparam aes_state_t ST_DRAIN = 3'd4;

endpackage

`default_nettype wire

// File: rtl/aes_word_shift.sv
// ============================================================================
// Module : aes_word_shift
// Brief  : 128-bit block register loaded one 32-bit word at a time; index 0
//          lands in the most significant word.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_word_shift
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [1:0]   i_idx,
   input  logic [31:0]  i_word,
   output logic [127:0] o_block
);

   logic [127:0] r_block;
   logic [6:0]   w_lsb;

   // Inverting the index maps word 0 to bits [127:96] and word 3 to [31:0].
   assign w_lsb = {~i_idx, 5'b0_0000};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_block <= '0;
      end else if (i_load) begin
         r_block[w_lsb +: 32] <= i_word;
      end
   end

   assign o_block = r_block;

endmodule

`default_nettype wire

// File: rtl/aes_in_loader.sv
// ============================================================================
// Module : aes_in_loader
// Brief  : Collects host words into key/data blocks, runs the AES core and
//          supervises completion with a cycle timeout.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_in_loader
   import aes_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
)
(
   input  logic         AES_clk,
   input  logic         AES_rst_n,
   input  logic         ld_word_valid,
   output logic         ld_word_ready,
   input  logic [31:0]  ld_word,
   input  logic         ld_key_reuse,
   input  logic         AES_data_out_valid,
   output logic         AES_en,
   output logic [127:0] AES_data_in,
   output logic [127:0] AES_key_in,
   output logic         busy,
   output logic         done,
   output logic         err_timeout
);

   localparam logic [1:0] c_LAST_IDX     = 2'(WORDS_PER_BLOCK - 1);
   localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

   aes_state_t r_state;
   logic [1:0] r_idx;
   logic [7:0] r_cnt;
   logic       r_key_loaded;
   logic       r_live;

   logic w_xfer;
   logic w_reuse;
   logic w_key_ld;
   logic w_dat_ld;
   logic w_last;
   logic w_run;
   logic w_to_hit;

   assign w_run    = (r_state == ST_RUN);
   assign w_xfer   = ld_word_valid & ld_word_ready;
   assign w_reuse  = ld_key_reuse & r_key_loaded;
   assign w_last   = (r_idx == c_LAST_IDX);
   assign w_to_hit = (r_cnt == c_TIMEOUT_LAST);

   assign w_key_ld = w_xfer & (((r_state == ST_IDLE) & ~w_reuse) | (r_state == ST_KEY));
   assign w_dat_ld = w_xfer & (((r_state == ST_IDLE) &  w_reuse) | (r_state == ST_DATA));

   // r_live keeps ready low while reset is held and for the release cycle.
   assign ld_word_ready = r_live & ((r_state == ST_IDLE) | (r_state == ST_KEY) |
                                    (r_state == ST_DATA));
   assign AES_en        = w_run;
   assign busy          = (r_state != ST_IDLE);
   assign done          = w_run & AES_data_out_valid;
   assign err_timeout   = w_run & ~AES_data_out_valid & w_to_hit;

   always_ff @(posedge AES_clk or negedge AES_rst_n) begin
      if (!AES_rst_n) begin
         r_state      <= ST_IDLE;
         r_idx        <= 2'd0;
         r_cnt        <= 8'd0;
         r_key_loaded <= 1'b0;
         r_live       <= 1'b0;
      end else begin
         r_live <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (w_xfer) begin
                  r_idx   <= 2'd1;
                  r_state <= w_reuse ? ST_DATA : ST_KEY;
               end
            end
            ST_KEY: begin
               if (w_xfer) begin
                  r_idx <= r_idx + 2'd1;
                  if (w_last) begin
                     r_key_loaded <= 1'b1;
                     r_state      <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (w_xfer) begin
                  r_idx <= r_idx + 2'd1;
                  if (w_last) begin
                     r_cnt   <= 8'd0;
                     r_state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               r_cnt <= r_cnt + 8'd1;
               if (AES_data_out_valid || w_to_hit) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   aes_word_shift u_key_reg (
      .clk     (AES_clk),
      .rst_n   (AES_rst_n),
      .i_load  (w_key_ld),
      .i_idx   (r_idx),
      .i_word  (ld_word),
      .o_block (AES_key_in)
   );

   aes_word_shift u_data_reg (
      .clk     (AES_clk),
      .rst_n   (AES_rst_n),
      .i_load  (w_dat_ld),
      .i_idx   (r_idx),
      .i_word  (ld_word),
      .o_block (AES_data_in)
   );

endmodule

`default_nettype wire

// File: doc/aes_in_loader.md
AES_IN_LOADER -- requirements
Module: aes_in_loader

Interface
REQ-001 TIMEOUT_CYC, 64, maximum cycles in RUN waiting for AES_data_out_valid (legal range 2..255).
REQ-002 AES_clk  in  1  single clock; all state updates on rising edge.
REQ-003 AES_rst_n  in  1  reset, asynchronous and active-low.
REQ-004 ld_word_valid  in  1  host word valid.
REQ-005 ld_word_ready  out  1  loader can accept a word.
REQ-006 ld_word  in  32  host word, most significant word first.
REQ-007 ld_key_reuse  in  1  sampled with first word of a job; 1 = skip key load, reuse stored key.
REQ-008 AES_data_out_valid  in  1  completion strobe from the AES core.
REQ-009 AES_en  out  1  enable to the AES core.
REQ-010 AES_data_in  out  128  plaintext block to the core.
REQ-011 AES_key_in  out  128  cipher key to the core.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse on successful completion.
REQ-014 err_timeout  out  1  one-cycle pulse on timeout abort.

Function
REQ-015 States SHALL be IDLE, KEY, DATA, RUN, DRAIN.
REQ-016 A word transfer SHALL occur only in a cycle with ld_word_valid and ld_word_ready both high.
REQ-017 ld_word_ready SHALL be high in IDLE, KEY and DATA, and low in RUN and DRAIN.
REQ-018 Words SHALL fill bits [127:96], [95:64], [63:32], [31:0] in transfer order.
REQ-019 IDLE, transfer, ld_key_reuse=0 or key_loaded=0: word SHALL be key word 0; next state KEY.
REQ-020 IDLE, transfer, ld_key_reuse=1 and key_loaded=1: word SHALL be data word 0; next state DATA; AES_key_in unchanged.
REQ-021 KEY: after key word 3 is accepted, key_loaded SHALL set and state SHALL go to DATA.
REQ-022 DATA: after data word 3 is accepted, state SHALL go to RUN; AES_en SHALL be high from the next cycle (1-cycle latency).
REQ-023 AES_en SHALL be high exactly while in RUN; AES_data_in and AES_key_in SHALL remain stable throughout RUN.
REQ-024 RUN: an 8-bit counter SHALL clear on entry and increment each cycle.
REQ-025 RUN with AES_data_out_valid=1: done SHALL pulse in the same cycle; next state DRAIN.
REQ-026 RUN with counter = TIMEOUT_CYC-1 and AES_data_out_valid=0: err_timeout SHALL pulse; next state DRAIN.
REQ-027 Valid and timeout in the same cycle: valid SHALL win; done pulses; err_timeout stays low.
REQ-028 DRAIN SHALL last exactly one cycle with AES_en low, then go to IDLE.
REQ-029 AES_data_out_valid outside RUN SHALL be ignored.
REQ-030 Stalls (ld_word_valid low) in KEY or DATA SHALL hold state, word index and partial contents indefinitely.
REQ-031 AES_data_in and AES_key_in SHALL keep their last values after a job ends, until overwritten.

Reset
REQ-032 Asserting AES_rst_n low SHALL immediately set state to IDLE, all outputs to 0, word index to 0, counter to 0, and key_loaded to 0, including mid-job.
REQ-033 ld_word_ready SHALL go high the first cycle after reset release.

Structure
REQ-034 Shared package aes_pkg SHALL hold the state enum, the words-per-block constant (4), and the TIMEOUT_CYC default.
REQ-035 A sub-module aes_word_shift (128-bit register, 32-bit word load with 2-bit index) SHALL be instantiated twice, for the key and for the data.

Verification
REQ-036 Full load: key aa2bdb40,bff6a5e8,caa9ba3e,bc1e2acc, then data 000000fc,0,0,0 -> AES_en high one cycle after word 8; AES_key_in=aa2bdb40bff6a5e8caa9ba3ebc1e2acc; AES_data_in=000000fc000...0.
REQ-037 Core valid 40 cycles into RUN -> done pulses that cycle; AES_en low for one DRAIN cycle; ready high the following cycle.
REQ-038 Key reuse: second job with ld_key_reuse=1 and data a6f2daeb,140fa720,529e75d5,21cbc681 -> only 4 words accepted; AES_key_in unchanged.
REQ-039 No core valid, TIMEOUT_CYC=64 -> err_timeout pulses on RUN cycle 64; done stays 0; then IDLE.
REQ-040 Valid on the timeout cycle -> done=1, err_timeout=0.
REQ-041 Reset asserted after 5 of 8 words, then ld_key_reuse=1 job -> treated as a key load (key_loaded cleared); all outputs 0 during reset.
